// File: rtl/led_pattern_driver_if.sv
// Bundle of the value/mode/brightness controls and the LED-side outputs of
// led_pattern_driver. The master drives the controls and the slave is the driver.
interface led_pattern_driver_if #(
    parameter int BITS     = 4,
    parameter int PWM_BITS = 4
);
    logic [BITS-1:0]     value;
    logic                value_valid;
    logic [1:0]          mode;
    logic [PWM_BITS-1:0] brightness;
    logic                value_ack;
    logic                tick;
    logic [BITS-1:0]     led;

    modport master (
        output value, value_valid, mode, brightness,
        input  value_ack, tick, led
    );

    modport slave (
        input  value, value_valid, mode, brightness,
        output value_ack, tick, led
    );
endinterface

// File: rtl/led_pattern_driver.sv
// LED pattern driver: turns the upstream counter value into direct, chase,
// bounce or blink patterns on the board LEDs, with PWM dimming.
// led[3] drives LD1 and led[0] drives LD4. Everything runs on clk, and a
// prescaler tick enable sets the pattern step rate.
module led_pattern_driver #(
    parameter int BITS      = 4,
    parameter int LOG2DELAY = 16,
    parameter int PWM_BITS  = 4
) (
    input logic                 clk,
    input logic                 rst,
    led_pattern_driver_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [BITS-1:0]      value_q, value_d;
    logic                 value_ack_q, value_ack_d;
    logic                 tick_q, tick_d;
    logic [BITS-1:0]      pattern_q, pattern_d;
    dir_e                 dir_q, dir_d;
    logic                 phase_q, phase_d;     // 1 = blink on-phase
    logic [LOG2DELAY-1:0] presc_q, presc_d;
    logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
    mode_e                mode_q, mode_d;
    logic [BITS-1:0]      led_q, led_d;

    logic                 mode_change;
    logic                 lit;
    logic [BITS-1:0]      display;
    logic [BITS-1:0]      shifted;

    // State register: synchronous active-high reset to the idle pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge values, whatever order the statements are in.
            value_q     <= '0;
            value_ack_q <= 1'b0;
            tick_q      <= 1'b0;
            pattern_q   <= BITS'(1);
            dir_q       <= DIR_UP;
            phase_q     <= 1'b1;
            presc_q     <= '0;
            pwm_cnt_q   <= '0;
            mode_q      <= MODE_DIRECT;
            led_q       <= '0;
        end else begin
            value_q     <= value_d;
            value_ack_q <= value_ack_d;
            tick_q      <= tick_d;
            pattern_q   <= pattern_d;
            dir_q       <= dir_d;
            phase_q     <= phase_d;
            presc_q     <= presc_d;
            pwm_cnt_q   <= pwm_cnt_d;
            mode_q      <= mode_d;
            led_q       <= led_d;
        end
    end

    // Next-state logic: value load, prescaler, mode restart and pattern stepping.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can leave one
        // unassigned and infer a latch.
        value_d     = value_q;
        value_ack_d = bus.value_valid;
        presc_d     = presc_q + 1'b1;
        pwm_cnt_d   = pwm_cnt_q + 1'b1;
        tick_d      = (presc_q == '1);
        pattern_d   = pattern_q;
        dir_d       = dir_q;
        phase_d     = phase_q;
        mode_d      = mode_q;
        shifted     = '0;
        mode_change = (mode_e'(bus.mode) != mode_q);

        // Latch the new value even on a tick or mode-change edge; the last strobe wins.
        if (bus.value_valid) begin
            value_d = bus.value;
        end

        if (mode_change) begin
            // A restart beats any pending tick, which is dropped without stepping.
            mode_d    = mode_e'(bus.mode);
            pattern_d = BITS'(1);
            dir_d     = DIR_UP;
            phase_d   = 1'b1;
            presc_d   = '0;
            tick_d    = 1'b0;
        end else if (tick_q) begin
            case (mode_q)
                MODE_CHASE: begin
                    pattern_d = {pattern_q[BITS-2:0], pattern_q[BITS-1]};
                end
                MODE_BOUNCE: begin
                    if (dir_q == DIR_UP) begin
                        shifted = pattern_q << 1;
                        if (shifted[BITS-1]) dir_d = DIR_DOWN;
                    end else begin
                        shifted = pattern_q >> 1;
                        if (shifted[0]) dir_d = DIR_UP;
                    end
                    pattern_d = shifted;
                end
                MODE_BLINK: begin
                    phase_d = ~phase_q;
                end
                default: ;
            endcase
        end
    end

    // Output path: pick the displayed pattern and gate it with the PWM duty.
    always_comb begin
        case (mode_q)
            MODE_DIRECT: display = value_q;
            MODE_BLINK:  display = phase_q ? value_q : '0;
            default:     display = pattern_q;
        endcase
        lit   = (bus.brightness == '1) || (pwm_cnt_q < bus.brightness);
        led_d = display & {BITS{lit}};
    end

    assign bus.value_ack = value_ack_q;
    assign bus.tick      = tick_q;
    assign bus.led       = led_q;

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed bench for led_pattern_driver with LOG2DELAY=2, so a tick comes every 4 cycles.
// Inputs are driven and outputs sampled on the falling edge of clk.
module tb_led_pattern_driver;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    led_pattern_driver_if #(.BITS(4), .PWM_BITS(4)) bus ();

    led_pattern_driver #(.BITS(4), .LOG2DELAY(2), .PWM_BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) until the tick pulse is visible at a falling edge.
    task automatic wait_tick(input string tag);
        int n;
        n = 0;
        while (bus.tick !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(bus.tick), 32'h1);
    endtask

    task automatic strobe(input logic [3:0] v);
        bus.value       = v;
        bus.value_valid = 1'b1;
        step(1);
        bus.value_valid = 1'b0;
    endtask

    logic [3:0] chase_exp  [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] bounce_exp [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                   4'b0010, 4'b0001, 4'b0010};
    int         pwm_levels [4] = '{4, 0, 14, 15};

    initial begin
        int cnt;
        int bad;

        rst             = 1'b1;
        bus.value       = 4'b0000;
        bus.value_valid = 1'b0;
        bus.mode        = 2'd0;
        bus.brightness  = 4'd15;

        // Reset held for three edges, then the first tick arrives four cycles later.
        step(3);
        rst = 1'b0;
        check("reset_led", 32'(bus.led), 32'h0);
        check("reset_ack", 32'(bus.value_ack), 32'h0);
        check("reset_tick", 32'(bus.tick), 32'h0);
        for (int i = 1; i <= 5; i++) begin
            step(1);
            check("first_tick", 32'(bus.tick), 32'(i == 4));
        end

        // DIRECT: ack the cycle after the strobe, led two cycles after, then held.
        strobe(4'b1010);
        check("direct_ack", 32'(bus.value_ack), 32'h1);
        step(1);
        check("direct_ack_drop", 32'(bus.value_ack), 32'h0);
        check("direct_led", 32'(bus.led), 32'b1010);
        for (int i = 0; i < 6; i++) begin
            step(1);
            check("direct_hold", 32'(bus.led), 32'b1010);
        end

        // Back-to-back strobes: two acks in a row, and the last value wins.
        bus.value       = 4'b0011;
        bus.value_valid = 1'b1;
        step(1);
        check("b2b_ack0", 32'(bus.value_ack), 32'h1);
        bus.value = 4'b0101;
        step(1);
        bus.value_valid = 1'b0;
        check("b2b_ack1", 32'(bus.value_ack), 32'h1);
        check("b2b_led0", 32'(bus.led), 32'b0011);
        step(1);
        check("b2b_ack_drop", 32'(bus.value_ack), 32'h0);
        check("b2b_led1", 32'(bus.led), 32'b0101);

        // PWM in DIRECT with value 1111: lit cycles out of every 16 equal brightness, except all-ones.
        strobe(4'b1111);
        step(1);
        foreach (pwm_levels[k]) begin
            bus.brightness = 4'(pwm_levels[k]);
            step(1);
            cnt = 0;
            bad = 0;
            for (int i = 0; i < 16; i++) begin
                if (bus.led == 4'b1111) cnt++;
                else if (bus.led != 4'b0000) bad++;
                step(1);
            end
            check($sformatf("pwm_lit_b%0d", pwm_levels[k]), 32'(cnt), 32'(pwm_levels[k] == 15 ? 16 : pwm_levels[k]));
            check($sformatf("pwm_partial_b%0d", pwm_levels[k]), 32'(bad), 32'h0);
        end

        // CHASE: rotate left once per tick, starting from 0001.
        bus.mode = 2'd1;
        step(2);
        check("chase_start", 32'(bus.led), 32'b0001);
        foreach (chase_exp[i]) begin
            wait_tick("chase_tick");
            step(2);
            check($sformatf("chase_%0d", i), 32'(bus.led), 32'(chase_exp[i]));
        end

        // Mode change in the tick cycle: the restart wins and the tick is dropped.
        wait_tick("chase_tick");
        bus.mode = 2'd2;
        step(2);
        check("bounce_start", 32'(bus.led), 32'b0001);
        foreach (bounce_exp[i]) begin
            wait_tick("bounce_tick");
            step(2);
            check($sformatf("bounce_%0d", i), 32'(bus.led), 32'(bounce_exp[i]));
        end

        // Leave BOUNCE mid-sequence: CHASE restarts at 0001.
        bus.mode = 2'd1;
        step(2);
        check("rechase_start", 32'(bus.led), 32'b0001);
        wait_tick("rechase_tick");
        step(2);
        check("rechase_step", 32'(bus.led), 32'b0010);

        // BLINK with the latched 1111: on, then off; a strobe during the tick cycle loads and toggles together.
        bus.mode = 2'd3;
        step(2);
        check("blink_on", 32'(bus.led), 32'b1111);
        wait_tick("blink_tick");
        step(2);
        check("blink_off", 32'(bus.led), 32'b0000);
        wait_tick("blink_tick");
        strobe(4'b0110);
        step(1);
        check("blink_load_toggle", 32'(bus.led), 32'b0110);

        // Reset mid-CHASE at 0100: everything returns to the reset state.
        bus.mode = 2'd1;
        step(2);
        check("chase2_start", 32'(bus.led), 32'b0001);
        wait_tick("chase2_tick");
        step(2);
        check("chase2_0010", 32'(bus.led), 32'b0010);
        wait_tick("chase2_tick");
        step(2);
        check("chase2_0100", 32'(bus.led), 32'b0100);
        rst      = 1'b1;
        bus.mode = 2'd0;
        step(1);
        rst = 1'b0;
        check("midrst_led", 32'(bus.led), 32'h0);
        check("midrst_tick", 32'(bus.tick), 32'h0);
        for (int i = 1; i <= 5; i++) begin
            step(1);
            check("midrst_tick_seq", 32'(bus.tick), 32'(i == 4));
            check("midrst_value_cleared", 32'(bus.led), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
